tagged_record_deserializer: RTL and testbench



---
 rtl/tagged_record_pkg.sv | 30 +++
 rtl/tagged_record_deserializer.sv | 131 +++++++++++++
 tb/tb_tagged_record_deserializer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tagged_record_pkg.sv
// Types shared by the tagged-record serializer and deserializer.
// Pure declarations; no logic, no latency.
// Backpressure is not applicable to a package.
package tagged_record_pkg;

    localparam int unsigned MAX_PAY = 8;

    typedef enum logic [1:0] {
        TAG_BYTE     = 2'd0,
        TAG_SHORTINT = 2'd1,
        TAG_INT      = 2'd2,
        TAG_LONGINT  = 2'd3
    } tag_e;

    typedef struct packed {
        tag_e        tag;
        logic [63:0] payload;
    } record_t;

    // Number of payload bytes that follow a tag byte.
    function automatic int unsigned tag_len(tag_e t);
        case (t)
            TAG_BYTE:     return 1;
            TAG_SHORTINT: return 2;
            TAG_INT:      return 4;
            default:      return MAX_PAY;
        endcase
    endfunction

endpackage

// File: rtl/tagged_record_deserializer.sv
// Reassembles byte-stream tagged records (tag, then N LSB-first payload bytes) into record_t.
// Latency: record valid the cycle after its last payload byte; one byte/cycle sustained.
// Backpressure: while a record waits, in_ready follows out_ready; illegal tags dropped and counted.
module tagged_record_deserializer
    import tagged_record_pkg::*;
#(
    parameter bit SIGN_EXTEND = 1'b1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output record_t          out_rec,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_TAG  = 2'd0,
        S_PAY  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    tag_e             r_tag;
    logic [2:0]       r_cnt;
    logic [63:0]      r_acc;
    logic             r_out_valid;
    record_t          r_out_rec;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    logic        w_xfer;
    logic        w_tag_legal;
    logic        w_tag_accept;
    logic        w_pay_accept;
    logic        w_out_xfer;
    tag_e        w_tag_in;
    logic [2:0]  w_cnt_load;
    logic [3:0]  w_len;
    logic [2:0]  w_idx;
    logic [5:0]  w_sbit;
    logic [63:0] w_acc_new;
    logic [63:0] w_mask;
    logic [63:0] w_ext;

    // in_ready is a function of state only, except while holding a record.
    assign in_ready     = (r_state == S_HOLD) ? out_ready : 1'b1;
    assign w_xfer       = in_valid && in_ready;
    assign w_out_xfer   = r_out_valid && out_ready;
    assign w_tag_legal  = (in_data[7:2] == 6'd0);
    assign w_tag_in     = tag_e'(in_data[1:0]);
    assign w_cnt_load   = 3'(tag_len(w_tag_in) - 1);
    // A byte taken in S_HOLD is the next frame's tag byte.
    assign w_tag_accept = w_xfer && ((r_state == S_TAG) || (r_state == S_HOLD));
    assign w_pay_accept = w_xfer && (r_state == S_PAY);
    assign w_len        = 4'(tag_len(r_tag));
    assign w_idx        = 3'(w_len - 4'd1 - {1'b0, r_cnt});
    assign w_sbit       = 6'({w_len, 3'b000} - 7'd1);

    assign out_valid = r_out_valid;
    assign out_rec   = r_out_rec;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_TAG:   if (w_xfer && w_tag_legal) w_state_nxt = S_PAY;
            S_PAY:   if (w_xfer && (r_cnt == 3'd0)) w_state_nxt = S_HOLD;
            S_HOLD:  if (out_ready) w_state_nxt = (w_xfer && w_tag_legal) ? S_PAY : S_TAG;
            default: w_state_nxt = S_TAG;
        endcase
    end

    // Accumulator with the incoming payload byte merged, then width-extended.
    always_comb begin
        w_acc_new = r_acc;
        w_acc_new[{w_idx, 3'b000} +: 8] = in_data;
        w_mask = (w_len == 4'd8) ? '1 : ((64'd1 << {w_len, 3'b000}) - 64'd1);
        w_ext  = w_acc_new & w_mask;
        if (SIGN_EXTEND && w_acc_new[w_sbit]) w_ext = w_ext | ~w_mask;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_TAG;
        else     r_state <= w_state_nxt;
    end

    // Tag/payload capture, output register and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag       <= TAG_BYTE;
            r_cnt       <= 3'd0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_rec   <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_out_xfer) r_out_valid <= 1'b0;
            if (w_tag_accept) begin
                if (w_tag_legal) begin
                    r_tag <= w_tag_in;
                    r_cnt <= w_cnt_load;
                    r_acc <= '0;
                end else begin
                    r_err_pulse <= 1'b1;
                    if (r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
                end
            end
            if (w_pay_accept) begin
                r_acc <= w_acc_new;
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd0) begin
                    r_out_rec   <= '{tag: r_tag, payload: w_ext};
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tagged_record_deserializer.sv
// Directed bench: two instances (sign- and zero-extending) fed the same byte stream.
// Expected records are queued by the stimulus and popped by a monitor on each output transfer.
// Direct checks cover reset, error pulse/counter, stall behaviour and back-to-back throughput.
module tb_tagged_record_deserializer;
    import tagged_record_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;

    logic       se_in_ready, se_out_valid, se_err_pulse;
    record_t    se_out_rec;
    logic [7:0] se_err_count;
    logic       ze_in_ready, ze_out_valid, ze_err_pulse;
    record_t    ze_out_rec;
    logic [7:0] ze_err_count;

    tagged_record_deserializer #(.SIGN_EXTEND(1'b1), .ERR_W(8)) u_se (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(se_in_ready),
        .in_data(in_data), .out_valid(se_out_valid), .out_ready(out_ready),
        .out_rec(se_out_rec), .err_pulse(se_err_pulse), .err_count(se_err_count)
    );

    tagged_record_deserializer #(.SIGN_EXTEND(1'b0), .ERR_W(8)) u_ze (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ze_in_ready),
        .in_data(in_data), .out_valid(ze_out_valid), .out_ready(out_ready),
        .out_rec(ze_out_rec), .err_pulse(ze_err_pulse), .err_count(ze_err_count)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    bit      done = 1'b0;
    record_t q_se[$];
    record_t q_ze[$];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input tag_e t, input logic [63:0] p_se, input logic [63:0] p_ze);
        q_se.push_back('{tag: t, payload: p_se});
        q_ze.push_back('{tag: t, payload: p_ze});
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the byte.
    task automatic send(input logic [7:0] b, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!se_in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) check("send_timeout", 66'(waits), 66'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$], output int total_waits);
        int w;
        total_waits = 0;
        foreach (bytes[i]) begin
            send(bytes[i], w);
            total_waits += w;
        end
    endtask

    task automatic monitor();
        record_t e;
        while (!done) begin
            @(negedge clk);
            if (!rst && out_ready && se_out_valid) begin
                if (q_se.size() == 0) check("se_unexpected_record", se_out_rec, 66'd0);
                else begin
                    e = q_se.pop_front();
                    check("se_record", se_out_rec, e);
                end
            end
            if (!rst && out_ready && ze_out_valid) begin
                if (q_ze.size() == 0) check("ze_unexpected_record", ze_out_rec, 66'd0);
                else begin
                    e = q_ze.pop_front();
                    check("ze_record", ze_out_rec, e);
                end
            end
        end
    endtask

    task automatic stimulus();
        int      w;
        record_t held;
        logic [7:0] seq[$];

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_out_valid", 66'(se_out_valid), 66'd0);
        check("reset_out_rec", se_out_rec, 66'd0);
        check("reset_err_pulse", 66'(se_err_pulse), 66'd0);
        check("reset_err_count", 66'(se_err_count), 66'd0);
        check("reset_in_ready", 66'(se_in_ready), 66'd1);

        // INT record and its output timing
        push_exp(TAG_INT, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678);
        seq = '{8'h02, 8'h78, 8'h56, 8'h34};
        send_seq(seq, w);
        check("int_not_early", 66'(se_out_valid), 66'd0);
        send(8'h12, w);
        check("int_valid_next_cycle", 66'(se_out_valid), 66'd1);

        // SHORTINT with sign bit set
        push_exp(TAG_SHORTINT, 64'hFFFF_FFFF_FFFF_8000, 64'h0000_0000_0000_8000);
        seq = '{8'h01, 8'h00, 8'h80};
        send_seq(seq, w);

        // Illegal tag, then a BYTE record
        send(8'h07, w);
        check("err_pulse_set", 66'(se_err_pulse), 66'd1);
        check("err_count_one", 66'(se_err_count), 66'd1);
        push_exp(TAG_BYTE, 64'h0000_0000_0000_005A, 64'h0000_0000_0000_005A);
        send(8'h00, w);
        check("err_pulse_single", 66'(se_err_pulse), 66'd0);
        check("err_count_held", 66'(se_err_count), 66'd1);
        send(8'h5A, w);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 8'hFF : 8'h04, w);
        check("err_count_saturated", 66'(se_err_count), 66'hFF);
        check("err_count_saturated_ze", 66'(ze_err_count), 66'hFF);

        // Output stall holds the record and blocks input
        out_ready = 1'b0;
        held = '{tag: TAG_BYTE, payload: 64'h77};
        push_exp(TAG_BYTE, 64'h77, 64'h77);
        seq = '{8'h00, 8'h77};
        send_seq(seq, w);
        in_valid = 1'b1;
        in_data  = 8'h03;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 66'(se_in_ready), 66'd0);
            check("stall_out_valid", 66'(se_out_valid), 66'd1);
            check("stall_out_rec", se_out_rec, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 66'(se_in_ready), 66'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("release_out_cleared", 66'(se_out_valid), 66'd0);
        push_exp(TAG_LONGINT, 64'h8807_0605_0403_0201, 64'h8807_0605_0403_0201);
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h88};
        send_seq(seq, w);
        check("longint_tag_taken_on_release", 66'(se_out_valid), 66'd1);

        // Back-to-back frames, no bubbles
        push_exp(TAG_BYTE, 64'h11, 64'h11);
        push_exp(TAG_BYTE, 64'h22, 64'h22);
        push_exp(TAG_BYTE, 64'h33, 64'h33);
        seq = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
        send_seq(seq, w);
        check("b2b_no_ready_drop", 66'(w), 66'd0);

        // Reset mid-frame discards the partial record
        @(posedge clk); #1;
        seq = '{8'h02, 8'hAA, 8'hBB};
        send_seq(seq, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 66'(se_out_valid), 66'd0);
        check("midrst_err_count", 66'(se_err_count), 66'd0);
        check("midrst_in_ready", 66'(se_in_ready), 66'd1);
        push_exp(TAG_BYTE, 64'hFFFF_FFFF_FFFF_FFCC, 64'h0000_0000_0000_00CC);
        seq = '{8'h00, 8'hCC};
        send_seq(seq, w);

        // Drain
        for (int i = 0; i < 20 && (q_se.size() != 0 || q_ze.size() != 0); i++) @(posedge clk);
        @(posedge clk); #1;
        check("se_queue_drained", 66'(q_se.size()), 66'd0);
        check("ze_queue_drained", 66'(q_ze.size()), 66'd0);
        done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
